// File: rtl/final_soc_led_pio.sv
`default_nettype none
// ============================================================================
// Module   : final_soc_led_pio
// Brief    : Avalon-MM output PIO with set/clear aliases and a one-shot pulse.
// Revision : 1.0
// ============================================================================
module final_soc_led_pio #(
    parameter int          WIDTH        = 8,
    parameter int unsigned RESET_VALUE  = 0,
    parameter int          PULSE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int c_cnt_w = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [2:0] c_addr_data     = 3'd0;
    localparam logic [2:0] c_addr_pulse    = 3'd1;
    localparam logic [2:0] c_addr_status   = 3'd2;
    localparam logic [2:0] c_addr_outset   = 3'd4;
    localparam logic [2:0] c_addr_outclear = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PULSING = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_pulse_mask;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_readdata;

    logic               w_wr;
    logic [WIDTH-1:0]   w_wd;
    logic               w_expire;
    logic [WIDTH-1:0]   w_mask_live;
    logic [WIDTH-1:0]   w_mask_cleared;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_wr           = chipselect & ~write_n;
    assign w_wd           = writedata[WIDTH-1:0];
    assign w_unused       = &{1'b0, writedata};
    assign w_expire       = (r_state == ST_PULSING) && (r_cnt == '0);
    // Mask as it stands after this edge's expiry, so a coincident write builds on it.
    assign w_mask_live    = w_expire ? '0 : r_pulse_mask;
    assign w_mask_cleared = w_mask_live & ~w_wd;

    always_comb begin
        w_rdata = '0;
        case (address)
            c_addr_data:   w_rdata = 32'(r_data);
            c_addr_pulse:  w_rdata = 32'(r_pulse_mask);
            c_addr_status: w_rdata[0] = (r_state == ST_PULSING);
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_data       <= WIDTH'(RESET_VALUE);
            r_pulse_mask <= '0;
            r_cnt        <= '0;
            r_readdata   <= '0;
        end else begin
            r_readdata <= w_rdata;

            if (r_state == ST_PULSING) begin
                if (w_expire) begin
                    r_pulse_mask <= '0;
                    r_state      <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
            end

            if (w_wr) begin
                case (address)
                    c_addr_data: begin
                        r_data       <= w_wd;
                        r_pulse_mask <= '0;
                        r_state      <= ST_IDLE;
                    end
                    c_addr_pulse: begin
                        if (w_wd != '0) begin
                            r_pulse_mask <= w_mask_live | w_wd;
                            r_cnt        <= c_cnt_load;
                            r_state      <= ST_PULSING;
                        end
                    end
                    c_addr_outset: begin
                        r_data <= r_data | w_wd;
                    end
                    c_addr_outclear: begin
                        r_data       <= r_data & ~w_wd;
                        r_pulse_mask <= w_mask_cleared;
                        if (w_mask_cleared == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data | r_pulse_mask;

endmodule
`default_nettype wire
